// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and constants for the mips_bus_mem slave.
//   state_t      - handshake FSM states
//   RESET_VECTOR - MIPS reset vector, default base of the instruction window
//   LFSR_SEED/TAPS - 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), right-shifting
//   lane_merge() - per-byte select between an old and a new word
package mips_bus_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [15:0] LFSR_SEED    = 16'hACE1;
   // taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
   localparam logic [15:0] LFSR_TAPS    = 16'h002D;

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      return res;
   endfunction

endpackage

// File: rtl/mips_bus_mem_if.sv
// mips_bus_mem_if: Avalon-style mips_cpu_bus plus the slave status outputs.
//   master: drives address/read/write/byteenable/writedata
//   slave : drives waitrequest/readdata/err/rd_count/wr_count
interface mips_bus_mem_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        err;
   logic [15:0] rd_count;
   logic [15:0] wr_count;

   modport master (output address, read, write, byteenable, writedata,
                   input  waitrequest, readdata, err, rd_count, wr_count);
   modport slave  (input  address, read, write, byteenable, writedata,
                   output waitrequest, readdata, err, rd_count, wr_count);
endinterface

// File: rtl/mips_bus_mem_wait_ctrl.sv
// mem_wait_ctrl: handshake FSM, wait-state counter and LFSR.
//   clk, rst_n      - clock, async active-low reset
//   i_req           - read or write requested by the master
//   o_waitrequest   - slave busy (forced high while in reset)
//   o_to_ack        - next edge enters ACK (read data is captured here)
//   o_ack           - access completes at this edge
//   o_drop          - master abandoned the request while waiting
module mem_wait_ctrl
   import mips_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 0,
   parameter bit RAND_WAIT   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   output logic o_waitrequest,
   output logic o_to_ack,
   output logic o_ack,
   output logic o_drop
);
   state_t      r_state, w_next;
   logic [3:0]  r_cnt, w_cnt_next;
   logic [15:0] r_lfsr;
   logic        w_adv;
   logic [3:0]  w_wait_n;

   // wait count uses the LFSR value before it advances for this request
   assign w_wait_n = RAND_WAIT ? 4'(r_lfsr % 16'(WAIT_CYCLES + 1)) : 4'(WAIT_CYCLES);
   assign o_ack    = (r_state == ACK) & i_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_lfsr  <= LFSR_SEED;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_adv) r_lfsr <= {^(r_lfsr & LFSR_TAPS), r_lfsr[15:1]};
      end
   end

   always_comb begin
      w_next        = r_state;
      w_cnt_next    = r_cnt;
      w_adv         = 1'b0;
      o_waitrequest = 1'b0;
      o_to_ack      = 1'b0;
      o_drop        = 1'b0;
      case (r_state)
         IDLE: if (i_req) begin
            o_waitrequest = 1'b1;
            w_adv         = 1'b1;
            if (w_wait_n == 4'd0) begin
               w_next   = ACK;
               o_to_ack = 1'b1;
            end else begin
               w_next     = WAIT;
               w_cnt_next = w_wait_n;
            end
         end
         WAIT: begin
            o_waitrequest = 1'b1;
            if (!i_req) begin
               w_next = IDLE;
               o_drop = 1'b1;
            end else if (r_cnt == 4'd1) begin
               w_next   = ACK;
               o_to_ack = 1'b1;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         ACK:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (!rst_n) o_waitrequest = 1'b1;
   end
endmodule

// File: rtl/mips_bus_mem.sv
// mips_bus_mem: cycle-accurate memory slave for the mips_cpu_bus.
//   clk   - clock, all state on rising edge
//   reset - async active-low reset (memory contents are kept)
//   bus   - slave side of mips_bus_mem_if: request in, waitrequest/readdata/
//           sticky err/rd_count/wr_count out
// Two windows: data RAM at DATA_BASE and instruction RAM at INSTR_BASE.
// Byte lanes are little-endian: byteenable[0] covers the lowest byte address.
module mips_bus_mem
   import mips_bus_pkg::*;
#(
   parameter int          DATA_WORDS  = 512,
   parameter int          INSTR_WORDS = 512,
   parameter logic [31:0] DATA_BASE   = 32'h0000_0000,
   parameter logic [31:0] INSTR_BASE  = RESET_VECTOR,
   parameter int          WAIT_CYCLES = 0,
   parameter bit          RAND_WAIT   = 1'b0
) (
   input logic           clk,
   input logic           reset,
   mips_bus_mem_if.slave bus
);
   localparam int DAW = $clog2(DATA_WORDS);
   localparam int IAW = $clog2(INSTR_WORDS);

   logic [31:0]    r_dmem [DATA_WORDS];
   logic [31:0]    r_imem [INSTR_WORDS];
   logic [31:0]    r_readdata;
   logic           r_err;
   logic [15:0]    r_rd_count, r_wr_count;

   logic           w_req, w_to_ack, w_ack, w_drop, w_wreq;
   logic           w_dhit, w_ihit, w_illegal;
   logic [31:0]    w_doff, w_ioff, w_rword;
   logic [DAW-1:0] w_didx;
   logic [IAW-1:0] w_iidx;

   assign w_req  = bus.read | bus.write;
   // unsigned offset compare: addresses below the base wrap to huge values
   assign w_doff = bus.address - DATA_BASE;
   assign w_ioff = bus.address - INSTR_BASE;
   assign w_dhit = w_doff < 32'(DATA_WORDS * 4);
   assign w_ihit = w_ioff < 32'(INSTR_WORDS * 4);
   assign w_didx = w_doff[DAW+1:2];
   assign w_iidx = w_ioff[IAW+1:2];

   assign w_illegal = (bus.read & bus.write) | (bus.address[1:0] != 2'b00) |
                      ~(w_dhit | w_ihit) | (bus.write & (bus.byteenable == 4'b0000));

   // data window wins if the two windows are configured to overlap
   assign w_rword = w_dhit ? r_dmem[w_didx] : r_imem[w_iidx];

   mem_wait_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .RAND_WAIT(RAND_WAIT)) u_ctrl (
      .clk           (clk),
      .rst_n         (reset),
      .i_req         (w_req),
      .o_waitrequest (w_wreq),
      .o_to_ack      (w_to_ack),
      .o_ack         (w_ack),
      .o_drop        (w_drop)
   );

   // commit happens only at the ACK edge, which a reset pulse can never reach
   always_ff @(posedge clk) begin
      if (w_ack & bus.write & ~w_illegal) begin
         if (w_dhit) r_dmem[w_didx] <= lane_merge(r_dmem[w_didx], bus.writedata, bus.byteenable);
         else        r_imem[w_iidx] <= lane_merge(r_imem[w_iidx], bus.writedata, bus.byteenable);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_readdata <= '0;
         r_err      <= 1'b0;
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else begin
         if (w_to_ack & bus.read)
            r_readdata <= w_illegal ? 32'h0 : lane_merge(32'h0, w_rword, bus.byteenable);
         if ((w_ack & w_illegal) | w_drop) r_err <= 1'b1;
         if (w_ack & ~w_illegal) begin
            if (bus.read)  r_rd_count <= r_rd_count + 16'd1;
            if (bus.write) r_wr_count <= r_wr_count + 16'd1;
         end
      end
   end

   assign bus.waitrequest = w_wreq;
   assign bus.readdata    = r_readdata;
   assign bus.err         = r_err;
   assign bus.rd_count    = r_rd_count;
   assign bus.wr_count    = r_wr_count;
endmodule

// File: tb/tb_mips_bus_mem.sv
// tb_mips_bus_mem: directed table plus hand sequences for mips_bus_mem.
// Three instances: fixed 0 wait states, fixed 3, random up to 7.
module tb_mips_bus_mem;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]        t_rd = '0, t_wr = '0;
   logic [2:0][31:0]  t_addr = '0, t_wd = '0;
   logic [2:0][3:0]   t_be = '0;
   logic [2:0]        t_wq, t_err;
   logic [2:0][31:0]  t_rdata;
   logic [2:0][15:0]  t_rc, t_wc;

   mips_bus_mem_if bus0 ();
   mips_bus_mem_if bus1 ();
   mips_bus_mem_if bus2 ();

   assign bus0.address = t_addr[0]; assign bus0.read = t_rd[0]; assign bus0.write = t_wr[0];
   assign bus0.byteenable = t_be[0]; assign bus0.writedata = t_wd[0];
   assign bus1.address = t_addr[1]; assign bus1.read = t_rd[1]; assign bus1.write = t_wr[1];
   assign bus1.byteenable = t_be[1]; assign bus1.writedata = t_wd[1];
   assign bus2.address = t_addr[2]; assign bus2.read = t_rd[2]; assign bus2.write = t_wr[2];
   assign bus2.byteenable = t_be[2]; assign bus2.writedata = t_wd[2];

   assign t_wq    = {bus2.waitrequest, bus1.waitrequest, bus0.waitrequest};
   assign t_err   = {bus2.err, bus1.err, bus0.err};
   assign t_rdata = {bus2.readdata, bus1.readdata, bus0.readdata};
   assign t_rc    = {bus2.rd_count, bus1.rd_count, bus0.rd_count};
   assign t_wc    = {bus2.wr_count, bus1.wr_count, bus0.wr_count};

   mips_bus_mem #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
   mips_bus_mem #(.WAIT_CYCLES(3)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
   mips_bus_mem #(.WAIT_CYCLES(7), .RAND_WAIT(1'b1)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   // one full handshake; wh = cycles with waitrequest high before the ACK cycle
   task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd,
                         output logic [31:0] rdata, output int wh);
      bit done;
      @(negedge clk);
      t_rd[d] = rd; t_wr[d] = wr; t_addr[d] = a; t_be[d] = be; t_wd[d] = wd;
      wh = 0; rdata = 'x; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (t_wq[d]) begin
            wh++;
            @(negedge clk);
         end else begin
            rdata = t_rdata[d];
            done  = 1'b1;
         end
      end
      chk("handshake_done", 32'(done), 32'd1);
      @(negedge clk);
      t_rd[d] = 1'b0; t_wr[d] = 1'b0;
   endtask

   typedef struct {
      int          d;
      bit          rd;
      bit          wr;
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      int          exp_wh;
   } vec_t;

   vec_t        vt[$];
   logic [31:0] rdata;
   int          wh;
   logic [31:0] mdl [16];
   logic [15:0] m_lfsr;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt.push_back('{0, 0, 1, 32'hBFC0_0000, 4'hF, 32'h2402_0005, 32'h0, 1});
      vt.push_back('{0, 1, 0, 32'hBFC0_0000, 4'hF, 32'h0, 32'h2402_0005, 1});
      vt.push_back('{0, 0, 1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0, 1});
      vt.push_back('{0, 0, 1, 32'h0000_0010, 4'h2, 32'hAABB_CCDD, 32'h0, 1});
      vt.push_back('{0, 1, 0, 32'h0000_0010, 4'hF, 32'h0, 32'h1122_CC44, 1});
      vt.push_back('{0, 1, 0, 32'h0000_0010, 4'h3, 32'h0, 32'h0000_CC44, 1});
      vt.push_back('{0, 0, 1, 32'h0000_0014, 4'hF, 32'h0, 32'h0, 1});
      vt.push_back('{0, 0, 1, 32'h0000_0014, 4'h9, 32'hDEAD_BEEF, 32'h0, 1});
      vt.push_back('{0, 1, 0, 32'h0000_0014, 4'hF, 32'h0, 32'hDE00_00EF, 1});
      vt.push_back('{0, 0, 1, 32'h0000_07FC, 4'hF, 32'h5A5A_5A5A, 32'h0, 1});
      vt.push_back('{0, 1, 0, 32'h0000_07FC, 4'hF, 32'h0, 32'h5A5A_5A5A, 1});
      vt.push_back('{0, 0, 1, 32'hBFC0_07FC, 4'hF, 32'h0BAD_F00D, 32'h0, 1});
      vt.push_back('{0, 1, 0, 32'hBFC0_07FC, 4'hC, 32'h0, 32'h0BAD_0000, 1});
      vt.push_back('{1, 0, 1, 32'h0000_0020, 4'hF, 32'hCAFE_F00D, 32'h0, 4});
      vt.push_back('{1, 1, 0, 32'h0000_0020, 4'hF, 32'h0, 32'hCAFE_F00D, 4});

      // reset state
      #12;
      chk("rst_waitrequest", 32'(t_wq), 32'h7);
      chk("rst_readdata", t_rdata[0], 32'h0);
      chk("rst_err", 32'(t_err), 32'h0);
      chk("rst_rd_count", 32'(t_rc[0]), 32'h0);
      chk("rst_wr_count", 32'(t_wc[1]), 32'h0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); #1;
      chk("idle_waitrequest", 32'(t_wq), 32'h0);

      foreach (vt[i]) begin
         access(vt[i].d, vt[i].rd, vt[i].wr, vt[i].a, vt[i].be, vt[i].wd, rdata, wh);
         chk($sformatf("vec%0d_wait", i), 32'(wh), 32'(vt[i].exp_wh));
         if (vt[i].rd) chk($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rd);
         if (i == 1) chk("fetch_rd_count", 32'(t_rc[0]), 32'd1);
      end
      chk("tbl_rd_count0", 32'(t_rc[0]), 32'd6);
      chk("tbl_wr_count0", 32'(t_wc[0]), 32'd7);
      chk("tbl_err0", 32'(t_err[0]), 32'd0);

      // illegal accesses on the zero-wait instance
      access(0, 1, 0, 32'h0000_0002, 4'hF, 32'h0, rdata, wh);
      chk("ill_misaligned_rdata", rdata, 32'h0);
      chk("ill_misaligned_wait", 32'(wh), 32'd1);
      chk("ill_err_set", 32'(t_err[0]), 32'd1);
      access(0, 0, 1, 32'h8000_0000, 4'hF, 32'hFFFF_FFFF, rdata, wh);
      access(0, 0, 1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, rdata, wh);
      access(0, 1, 0, 32'h0000_0800, 4'hF, 32'h0, rdata, wh);
      chk("ill_window_end_rdata", rdata, 32'h0);
      access(0, 1, 1, 32'h0000_0010, 4'hF, 32'hFFFF_FFFF, rdata, wh);
      chk("ill_rdwr_rdata", rdata, 32'h0);
      chk("ill_rd_count", 32'(t_rc[0]), 32'd6);
      chk("ill_wr_count", 32'(t_wc[0]), 32'd7);
      access(0, 1, 0, 32'h0000_0010, 4'hF, 32'h0, rdata, wh);
      chk("ill_mem_unchanged", rdata, 32'h1122_CC44);
      chk("ill_err_sticky", 32'(t_err[0]), 32'd1);
      chk("ill_rd_count_after", 32'(t_rc[0]), 32'd7);

      // request dropped while waiting
      chk("drop_err_before", 32'(t_err[1]), 32'd0);
      @(negedge clk);
      t_rd[1] = 1'b1; t_addr[1] = 32'h20; t_be[1] = 4'hF;
      @(negedge clk);
      t_rd[1] = 1'b0;
      @(negedge clk); #1;
      chk("drop_err", 32'(t_err[1]), 32'd1);
      chk("drop_rd_count", 32'(t_rc[1]), 32'd1);
      chk("drop_idle_wait", 32'(t_wq[1]), 32'd0);

      // reset during the wait phase of a write
      access(1, 0, 1, 32'h30, 4'hF, 32'h1111_1111, rdata, wh);
      chk("pre_reset_wait", 32'(wh), 32'd4);
      @(negedge clk);
      t_wr[1] = 1'b1; t_addr[1] = 32'h30; t_be[1] = 4'hF; t_wd[1] = 32'h2222_2222;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_waitrequest", 32'(t_wq[1]), 32'd1);
      chk("mid_rst_readdata", t_rdata[1], 32'h0);
      chk("mid_rst_err", 32'(t_err[1]), 32'd0);
      chk("mid_rst_wr_count", 32'(t_wc[1]), 32'd0);
      chk("mid_rst_rd_count", 32'(t_rc[1]), 32'd0);
      @(negedge clk); t_wr[1] = 1'b0;
      @(negedge clk); reset = 1'b1;
      access(1, 1, 0, 32'h30, 4'hF, 32'h0, rdata, wh);
      chk("abort_no_commit", rdata, 32'h1111_1111);
      chk("abort_rd_count", 32'(t_rc[1]), 32'd1);

      // random wait states against a scoreboard and an LFSR reference
      m_lfsr = 16'hACE1;
      for (int k = 0; k < 216; k++) begin
         bit          rd;
         int          idx, exp_wh;
         logic [3:0]  be;
         logic [31:0] wd;
         idx = (k < 16) ? k : int'($urandom_range(0, 15));
         rd  = (k >= 16) && ($urandom_range(0, 1) == 1);
         wd  = $urandom;
         be  = (k < 16) ? 4'hF : 4'($urandom_range(1, 15));
         exp_wh = int'(m_lfsr % 16'd8) + 1;
         m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
         access(2, rd, !rd, 32'h100 + 32'(idx * 4), be, wd, rdata, wh);
         checks++;
         if (wh < 1 || wh > 8) begin
            errors++;
            $display("FAIL rand%0d_wait_range: got %0d expected 1..8", k, wh);
         end
         chk($sformatf("rand%0d_wait", k), 32'(wh), 32'(exp_wh));
         if (rd) chk($sformatf("rand%0d_rdata", k), rdata, merge(32'h0, mdl[idx], be));
         else    mdl[idx] = merge((k < 16) ? 32'h0 : mdl[idx], wd, be);
      end
      chk("rand_err", 32'(t_err[2]), 32'd0);
      chk("rand_total", 32'(t_rc[2]) + 32'(t_wc[2]), 32'd216);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
